jump_imm_buffer: RTL and testbench
==================================

JUMP_IMM_BUFFER -- requirements
Module: jump_imm_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand data width.
REQ-002 SHALL have parameter VADDR_BITS, default 39, jump PC/target width (must be < XLEN).
REQ-003 SHALL have parameter DEPTH, default 16, number of PC/target entries (power of 2, >= 2); AW = log2(DEPTH).
REQ-004 SHALL have parameter NUM_SRC, default 2, operand sources per uop (>= 2).
REQ-005 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: wen  in  1  entry write strobe; waddr  in  AW  entry index; wpc  in  VADDR_BITS  jump PC; wtarget  in  VADDR_BITS  jalr target.
REQ-007 SHALL have ports: flush  in  1  redirect; clears all entries and drops the output.
REQ-008 SHALL have ports: in_valid  in  1; in_ready  out  1; in_idx  in  AW  entry to read; in_srcType  in  2*NUM_SRC  per-source type, source i at [2i+1:2i]; in_data  in  XLEN*NUM_SRC  source i at [XLEN*i +: XLEN].
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  XLEN*NUM_SRC  same packing as in_data; out_miss  out  1  read entry was invalid.

Function
REQ-010 SHALL hold per entry a valid bit, pc and target registers; wen writes pc/target at waddr and sets its valid bit on the next edge.
REQ-011 SHALL accept a request when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-012 SHALL register results: accepted request appears on out_valid/out_data/out_miss exactly 1 cycle later.
REQ-013 SHALL hold out_valid, out_data, out_miss stable while out_valid && !out_ready.
REQ-014 SHALL deassert out_valid after an out_valid && out_ready cycle with no new accept; back-to-back accept gives 1 result/cycle.
REQ-015 SHALL compute source 0: srcType[1:0]==2'b01 -> sign-extend pc to XLEN (bit VADDR_BITS-1 replicated); else in_data source 0.
REQ-016 SHALL compute source 1: srcType[0]==1 -> zero-extend target to XLEN; else in_data source 1.
REQ-017 SHALL pass sources 2..NUM_SRC-1 through unchanged regardless of srcType.
REQ-018 SHALL bypass: if wen && waddr==in_idx in the accept cycle, use wpc/wtarget and treat entry as valid.
REQ-019 SHALL set out_miss=1 when read entry invalid (no bypass); substitutions still performed using stored (stale/zero) values.
REQ-020 SHALL on flush: clear all valid bits, drop out_valid next cycle, ignore in_valid and wen in the same cycle; in_ready unaffected combinationally.
REQ-021 SHALL, if flush and out_ready both high, treat the current output as dropped (no second presentation).
REQ-022 SHALL not change entry pc/target on read; the same entry may be read any number of times.

Reset
REQ-023 SHALL on reset: out_valid=0, out_miss=0, out_data=0, all valid bits 0; pc/target contents need not be reset.
REQ-024 SHALL give reset priority over flush, wen and accept in the same cycle.
REQ-025 SHALL abort an in-flight result when reset is asserted mid-operation; after reset deasserts in_ready=1.

Verification
REQ-026 Write idx 3 pc=0x40_0000_1000 (bit38=1), next cycle read idx3 srcType0=01 -> out_data src0=0xFFFF_FFC0_0000_1000 one cycle later, out_miss=0.
REQ-027 Write idx5 target=0x00_8000_0004, read idx5 srcType1=2'b11, in_data src1=0xDEAD -> src1=0x0000_0000_8000_0004; srcType1=2'b10 -> 0xDEAD.
REQ-028 Same-cycle wen idx7 pc=0x123 and read idx7 srcType0=01 -> src0=0x123, out_miss=0 (bypass).
REQ-029 Read idx2 after reset with no write -> out_miss=1; out_ready=0 for 3 cycles -> outputs stable, in_ready=0 throughout.
REQ-030 Back-to-back 4 reads with out_ready=1 -> 4 consecutive results; flush at 3rd -> out_valid=0 next cycle, subsequent read of idx3 -> out_miss=1.

Source files
------------

// File: rtl/jump_imm_buffer.sv
// Jump immediate buffer: holds per-entry jump PC/target and substitutes them
// into uop operands on a one-cycle registered, ready/valid-handshaked read path.
module jump_imm_buffer #(
  parameter  int XLEN       = 64,
  parameter  int VADDR_BITS = 39,
  parameter  int DEPTH      = 16,
  parameter  int NUM_SRC    = 2,
  localparam int AW         = $clog2(DEPTH),
  localparam int DW         = XLEN * NUM_SRC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [VADDR_BITS-1:0] wpc,
  input  logic [VADDR_BITS-1:0] wtarget,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         in_idx,
  input  logic [2*NUM_SRC-1:0]  in_srcType,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_miss
);

  logic [VADDR_BITS-1:0] pc_q  [DEPTH];
  logic [VADDR_BITS-1:0] tgt_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_miss_q, out_miss_d;
  logic [DW-1:0]         out_data_q, out_data_d;

  logic                  accept;
  logic                  write_en;
  logic                  bypass_hit;
  logic [VADDR_BITS-1:0] rd_pc, rd_tgt;
  logic [DW-1:0]         subst_data;
  logic                  srctype_unused;

  // Only source 0's full type and source 1's low bit steer substitution.
  assign srctype_unused = ^in_srcType;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign write_en   = wen && !flush;
  assign bypass_hit = write_en && (waddr == in_idx);
  assign rd_pc      = bypass_hit ? wpc     : pc_q[in_idx];
  assign rd_tgt     = bypass_hit ? wtarget : tgt_q[in_idx];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    subst_data = in_data;
    if (in_srcType[1:0] == 2'b01)
      subst_data[XLEN-1:0] = {{(XLEN-VADDR_BITS){rd_pc[VADDR_BITS-1]}}, rd_pc};
    if (in_srcType[2])
      subst_data[XLEN +: XLEN] = {{(XLEN-VADDR_BITS){1'b0}}, rd_tgt};
  end

  always_comb begin
    valid_d     = valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_miss_d  = out_miss_q;
    if (flush) begin
      // A flush drops the presented result even if it is being consumed.
      valid_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (write_en)
        valid_d[waddr] = 1'b1;
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = subst_data;
        out_miss_d  = !(bypass_hit || valid_q[in_idx]);
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_miss_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_miss_q  <= out_miss_d;
    end
  end

  // NOTE: pc/target storage is deliberately not reset; the valid bits gate its use.
  always_ff @(posedge clock) begin
    if (!reset && write_en) begin
      pc_q[waddr]  <= wpc;
      tgt_q[waddr] <= wtarget;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_miss  = out_miss_q;

endmodule

// File: tb/tb_jump_imm_buffer.sv
// Directed bench for jump_imm_buffer: entry-level reference model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_jump_imm_buffer;

  localparam int XLEN  = 64;
  localparam int VB    = 39;
  localparam int DEPTH = 16;
  localparam int NS    = 3;
  localparam int AW    = 4;
  localparam int DW    = XLEN * NS;

  logic          clock = 1'b0;
  logic          reset;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [VB-1:0] wpc, wtarget;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_idx;
  logic [2*NS-1:0] in_srcType;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_miss;

  int errors = 0;
  int checks = 0;

  jump_imm_buffer #(.XLEN(XLEN), .VADDR_BITS(VB), .DEPTH(DEPTH), .NUM_SRC(NS)) dut (
    .clock(clock), .reset(reset), .wen(wen), .waddr(waddr), .wpc(wpc),
    .wtarget(wtarget), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_srcType(in_srcType), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_miss(out_miss)
  );

  always #5 clock = ~clock;

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [XLEN-1:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [DW-1:0] src(input int i);
    return DW'(out_data[i*XLEN +: XLEN]);
  endfunction

  // Reference model: entry table plus the single expected output slot.
  logic [DEPTH-1:0] m_vld;
  logic [VB-1:0]    m_pc [DEPTH];
  logic [VB-1:0]    m_tg [DEPTH];
  logic             m_valid = 1'b0;
  logic             m_miss  = 1'b0;
  logic [DW-1:0]    m_data  = '0;
  logic             model_live = 1'b0;

  always @(posedge clock) begin : model
    logic          hit;
    logic [VB-1:0] pcv, tgv;
    logic [XLEN-1:0] w;
    logic [DW-1:0] res;
    if (reset) begin
      m_vld      <= '0;
      m_valid    <= 1'b0;
      m_miss     <= 1'b0;
      m_data     <= '0;
      model_live <= 1'b1;
    end else if (flush) begin
      m_vld   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        hit = wen && (waddr == in_idx);
        pcv = hit ? wpc : m_pc[in_idx];
        tgv = hit ? wtarget : m_tg[in_idx];
        res = in_data;
        for (int s = 0; s < NS; s++) begin
          w = in_data[s*XLEN +: XLEN];
          if (s == 0 && in_srcType[1:0] == 2'b01) begin
            w = XLEN'(pcv);
            if (pcv[VB-1]) w = w | ~((64'd1 << VB) - 64'd1);
          end
          if (s == 1 && in_srcType[2]) w = XLEN'(tgv);
          res[s*XLEN +: XLEN] = w;
        end
        m_data  <= res;
        m_miss  <= !(hit || m_vld[in_idx]);
        m_valid <= 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (wen) begin
        m_vld[waddr] <= 1'b1;
        m_pc[waddr]  <= wpc;
        m_tg[waddr]  <= wtarget;
      end
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      check_b("model_out_valid", out_valid, m_valid);
      check_b("model_in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) begin
        check_w("model_out_data", out_data, m_data);
        check_b("model_out_miss", out_miss, m_miss);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [VB-1:0] p, input logic [VB-1:0] t);
    wen = 1'b1; waddr = a; wpc = p; wtarget = t;
    step();
    wen = 1'b0;
  endtask

  task automatic set_read(input logic [AW-1:0] idx, input logic [2*NS-1:0] st, input logic [DW-1:0] d);
    in_valid = 1'b1; in_idx = idx; in_srcType = st; in_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wen = 1'b0; waddr = '0; wpc = '0; wtarget = '0; flush = 1'b0;
    in_valid = 1'b0; in_idx = '0; in_srcType = '0; in_data = '0; out_ready = 1'b1;
    step(); step();
    check_b("reset_out_valid", out_valid, 1'b0);
    check_b("reset_out_miss", out_miss, 1'b0);
    check_w("reset_out_data", out_data, '0);
    check_b("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Sign-extended PC substitution from a previously written entry.
    do_write(4'd3, 39'h40_0000_1000, 39'h1);
    set_read(4'd3, 6'b00_00_01, pack(64'hAAAA, 64'hBBBB, 64'hCCCC));
    step();
    in_valid = 1'b0;
    check_b("t1_valid", out_valid, 1'b1);
    check_w("t1_src0", src(0), DW'(64'hFFFF_FFC0_0000_1000));
    check_w("t1_src1", src(1), DW'(64'hBBBB));
    check_w("t1_src2", src(2), DW'(64'hCCCC));
    check_b("t1_miss", out_miss, 1'b0);
    step();
    check_b("t1_drain", out_valid, 1'b0);

    // Target zero-extension keyed on bit 0 of source 1 type; source 2 untouched.
    do_write(4'd5, 39'h0, 39'h00_8000_0004);
    set_read(4'd5, 6'b10_11_00, pack(64'h1111, 64'hDEAD, 64'h2222));
    step();
    check_w("t2_src1_tgt", src(1), DW'(64'h0000_0000_8000_0004));
    check_w("t2_src0", src(0), DW'(64'h1111));
    check_w("t2_src2", src(2), DW'(64'h2222));
    set_read(4'd5, 6'b11_10_01, pack(64'h1111, 64'hDEAD, 64'h2222));
    step();
    check_w("t2_src1_pass", src(1), DW'(64'hDEAD));
    check_w("t2_src0_pc0", src(0), DW'(64'h0));
    in_valid = 1'b0;
    step();

    // Same-cycle write and read of one entry takes the bypass.
    wen = 1'b1; waddr = 4'd7; wpc = 39'h123; wtarget = 39'h77;
    set_read(4'd7, 6'b00_01_01, pack(64'h1, 64'h2, 64'h3));
    step();
    wen = 1'b0; in_valid = 1'b0;
    check_w("t3_src0", src(0), DW'(64'h123));
    check_w("t3_src1", src(1), DW'(64'h77));
    check_b("t3_miss", out_miss, 1'b0);
    step();

    // Miss after reset, then backpressure holds the result stable.
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0;
    set_read(4'd2, 6'b00_00_00, pack(64'h5, 64'h6, 64'h7));
    step();
    check_b("t4_valid", out_valid, 1'b1);
    check_b("t4_miss", out_miss, 1'b1);
    set_read(4'd3, 6'b00_00_00, pack(64'h8, 64'h9, 64'hA));
    for (int i = 0; i < 3; i++) begin
      check_b("t4_in_ready_low", in_ready, 1'b0);
      step();
      check_w("t4_hold_data", out_data, pack(64'h5, 64'h6, 64'h7));
      check_b("t4_hold_miss", out_miss, 1'b1);
    end
    // Reset aborts the stalled result.
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_b("t4_abort_valid", out_valid, 1'b0);
    check_b("t4_abort_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Back-to-back reads; a flush on the third drops the output and all entries.
    do_write(4'd3, 39'h40_0000_1000, 39'h31);
    do_write(4'd5, 39'h500, 39'h51);
    do_write(4'd7, 39'h700, 39'h71);
    do_write(4'd9, 39'h900, 39'h91);
    set_read(4'd3, 6'b00_01_01, pack(64'h10, 64'h11, 64'h12));
    step();
    check_w("t5_r1_src0", src(0), DW'(64'hFFFF_FFC0_0000_1000));
    check_w("t5_r1_src1", src(1), DW'(64'h31));
    set_read(4'd5, 6'b00_01_01, pack(64'h20, 64'h21, 64'h22));
    step();
    check_w("t5_r2_src0", src(0), DW'(64'h500));
    check_b("t5_r2_valid", out_valid, 1'b1);
    set_read(4'd7, 6'b00_01_01, pack(64'h30, 64'h31, 64'h32));
    flush = 1'b1; wen = 1'b1; waddr = 4'd11; wpc = 39'hB00; wtarget = 39'hB1;
    step();
    flush = 1'b0; wen = 1'b0;
    check_b("t5_flush_valid", out_valid, 1'b0);
    set_read(4'd9, 6'b00_00_00, pack(64'h40, 64'h41, 64'h42));
    step();
    check_b("t5_r4_miss", out_miss, 1'b1);
    check_w("t5_r4_data", out_data, pack(64'h40, 64'h41, 64'h42));
    set_read(4'd3, 6'b00_00_01, pack(64'h50, 64'h51, 64'h52));
    step();
    check_b("t5_idx3_miss", out_miss, 1'b1);
    check_w("t5_idx3_stale", src(0), DW'(64'hFFFF_FFC0_0000_1000));
    set_read(4'd11, 6'b00_00_00, pack(64'h60, 64'h61, 64'h62));
    step();
    check_b("t5_idx11_miss", out_miss, 1'b1);
    in_valid = 1'b0;
    step();
    check_b("t5_idle", out_valid, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
